// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for the
// shared handshake RAM of the MC14500B system. Requester 0 is the CPU,
// requester 1 the loader/debug port. Each four-phase requester transaction
// becomes a write-strobe pulse or a req_prev/req_next/ack_next read
// handshake on the RAM pins. Every output is registered.

module ram_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int WRITE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            rq_req,
    input  logic [1:0]            rq_write,
    input  logic [ADDR_WIDTH-1:0] rq_addr0,
    input  logic [ADDR_WIDTH-1:0] rq_addr1,
    input  logic [DATA_WIDTH-1:0] rq_wdata0,
    input  logic [DATA_WIDTH-1:0] rq_wdata1,
    output logic [1:0]            rq_ack,
    output logic [1:0]            rq_err,
    output logic [DATA_WIDTH-1:0] rq_rdata,
    output logic                  ram_write,
    output logic                  ram_req,
    output logic                  ram_ack_next,
    output logic                  ram_reset,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_done,
    input  logic                  ram_ack
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_HI,
        WR_LO,
        RD_REQ,
        RD_REL,
        RESP,
        ABORT
    } state_t;

    // One counter serves both the write-strobe length and the handshake timeout.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > WRITE_CYCLES) ? TIMEOUT_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    grant_q, grant_d;
    logic                    wr_q, wr_d;
    logic                    err_flag_q, err_flag_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              ack_q, ack_d;
    logic [1:0]              err_q, err_d;
    logic                    ram_write_q, ram_write_d;
    logic                    ram_req_q, ram_req_d;
    logic                    ram_ack_next_q, ram_ack_next_d;
    logic                    ram_reset_q, ram_reset_d;
    logic [SYNC_STAGES-1:0]  done_sync_q, done_sync_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;
    logic                    done_s;
    logic                    ack_s;

    assign done_s = done_sync_q[SYNC_STAGES-1];
    assign ack_s  = ack_sync_q[SYNC_STAGES-1];

    // Shift the asynchronous RAM status pins through their synchronizer chains.
    always_comb begin
        done_sync_d = {done_sync_q[SYNC_STAGES-2:0], ram_done};
        ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], ram_ack};
    end

    // Next-state, latched-request and registered-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        wr_d       = wr_q;
        err_flag_d = err_flag_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (|rq_req) begin
                    grant_d    = rq_req[ptr_q] ? ptr_q : ~ptr_q;
                    wr_d       = rq_write[grant_d];
                    addr_d     = grant_d ? rq_addr1 : rq_addr0;
                    wdata_d    = grant_d ? rq_wdata1 : rq_wdata0;
                    err_flag_d = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = wr_q ? WR_HI : RD_REQ;
            end
            WR_HI: begin
                if (cnt_q == WR_LAST) begin
                    state_d = WR_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_LO: begin
                state_d = RESP;
            end
            RD_REQ: begin
                if (done_s) begin
                    rdata_d = ram_rdata;
                    cnt_d   = '0;
                    state_d = RD_REL;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_REL: begin
                if (!done_s && !ack_s) begin
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ABORT: begin
                rdata_d    = '0;
                err_flag_d = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (!rq_req[grant_q]) begin
                    ptr_d   = ~grant_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ram_write_d    = (state_d == WR_HI);
        ram_req_d      = (state_d == RD_REQ);
        ram_ack_next_d = (state_d == RD_REL);
        ram_reset_d    = (state_d == ABORT);
        ack_d          = 2'b00;
        err_d          = 2'b00;
        if (state_d == RESP) begin
            ack_d[grant_d] = 1'b1;
            err_d[grant_d] = err_flag_d;
        end
    end

    // State register; a low reset drops every strobe at once and resets the RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            ptr_q          <= 1'b0;
            grant_q        <= 1'b0;
            wr_q           <= 1'b0;
            err_flag_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            cnt_q          <= '0;
            ack_q          <= 2'b00;
            err_q          <= 2'b00;
            ram_write_q    <= 1'b0;
            ram_req_q      <= 1'b0;
            ram_ack_next_q <= 1'b0;
            ram_reset_q    <= 1'b1;
            done_sync_q    <= '0;
            ack_sync_q     <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            wr_q           <= wr_d;
            err_flag_q     <= err_flag_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            cnt_q          <= cnt_d;
            ack_q          <= ack_d;
            err_q          <= err_d;
            ram_write_q    <= ram_write_d;
            ram_req_q      <= ram_req_d;
            ram_ack_next_q <= ram_ack_next_d;
            ram_reset_q    <= ram_reset_d;
            done_sync_q    <= done_sync_d;
            ack_sync_q     <= ack_sync_d;
        end
    end

    assign rq_ack       = ack_q;
    assign rq_err       = err_q;
    assign rq_rdata     = rdata_q;
    assign ram_write    = ram_write_q;
    assign ram_req      = ram_req_q;
    assign ram_ack_next = ram_ack_next_q;
    assign ram_reset    = ram_reset_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized transactions against ram_arbiter,
// with a reactive handshake RAM and a transaction-level memory/round-robin model.

module tb_ram_arbiter;

    localparam int DW        = 8;
    localparam int AW        = 8;
    localparam int SYNC      = 2;
    localparam int WRC       = 2;
    localparam int TOC       = 64;
    localparam int RAM_DELAY = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    rq_req;
    logic [1:0]    rq_write;
    logic [AW-1:0] rq_addr0, rq_addr1;
    logic [DW-1:0] rq_wdata0, rq_wdata1;
    logic [1:0]    rq_ack;
    logic [1:0]    rq_err;
    logic [DW-1:0] rq_rdata;
    logic          ram_write, ram_req, ram_ack_next, ram_reset;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_done;
    logic          ram_ack;

    int checks       = 0;
    int failures     = 0;
    int reset_pulses = 0;
    bit ram_hang     = 1'b0;
    int exp_ptr      = 0;

    logic [DW-1:0] exp_mem   [256];
    bit            exp_valid [256];
    logic [DW-1:0] ram_mem   [256];

    ram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC),
        .WRITE_CYCLES(WRC), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk(clk), .reset(reset),
        .rq_req(rq_req), .rq_write(rq_write),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .rq_ack(rq_ack), .rq_err(rq_err), .rq_rdata(rq_rdata),
        .ram_write(ram_write), .ram_req(ram_req), .ram_ack_next(ram_ack_next),
        .ram_reset(ram_reset), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_done(ram_done), .ram_ack(ram_ack)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int who, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (who == 0) begin
            rq_addr0  = addr;
            rq_wdata0 = data;
        end else begin
            rq_addr1  = addr;
            rq_wdata1 = data;
        end
        rq_write[who] = wr;
        rq_req[who]   = 1'b1;
    endtask

    // Handshake RAM: write on strobe, raise req_next RAM_DELAY cycles after req_prev,
    // drop it once ack_next is seen with req_prev low; ack_prev follows req_prev.
    initial begin
        int cnt;
        cnt       = 0;
        ram_done  = 1'b0;
        ram_ack   = 1'b0;
        ram_rdata = '0;
        forever begin
            @(negedge clk);
            if (ram_reset === 1'b1) begin
                ram_done  = 1'b0;
                ram_ack   = 1'b0;
                cnt       = 0;
                ram_rdata = DW'($urandom);
            end else begin
                if (ram_write === 1'b1) ram_mem[ram_addr] = ram_wdata;
                if (ram_done && ram_ack_next === 1'b1 && ram_req === 1'b0) begin
                    ram_done = 1'b0;
                    cnt      = 0;
                end else if (ram_req === 1'b1 && !ram_done) begin
                    cnt++;
                    if (!ram_hang && cnt >= RAM_DELAY) begin
                        ram_done  = 1'b1;
                        ram_rdata = ram_mem[ram_addr];
                    end
                end
                if (ram_req === 1'b0) cnt = 0;
                ram_ack = (ram_req === 1'b1);
                if (!ram_done) ram_rdata = DW'($urandom);
            end
        end
    end

    // Protocol monitor: strobe exclusivity, handshake ordering, ram_reset pulse count.
    initial begin
        int   done_hi;
        int   done_lo;
        logic prev_ack_next;
        logic prev_ram_reset;
        logic [1:0] prev_rq_ack;
        done_hi        = 0;
        done_lo        = 0;
        prev_ack_next  = 1'b0;
        prev_ram_reset = 1'b0;
        prev_rq_ack    = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (ram_done === 1'b1) begin
                done_hi++;
                done_lo = 0;
            end else begin
                done_lo++;
                done_hi = 0;
            end
            if (ram_req === 1'b1 || ram_write === 1'b1)
                checkOutput("req_write_exclusive", 32'(ram_req & ram_write), 32'd0);
            if (ram_ack_next === 1'b1 && prev_ack_next !== 1'b1)
                checkOutput("ack_next_rise_after_done_s", 32'(done_hi >= SYNC + 1), 32'd1);
            if (ram_ack_next !== 1'b1 && prev_ack_next === 1'b1 && ram_reset !== 1'b1)
                checkOutput("ack_next_fall_after_done_low", 32'(done_lo >= SYNC + 1), 32'd1);
            for (int i = 0; i < 2; i++) begin
                if (rq_ack[i] === 1'b1 && prev_rq_ack[i] !== 1'b1)
                    checkOutput("rq_ack_after_ack_next_low", 32'(ram_ack_next), 32'd0);
            end
            if (ram_reset === 1'b1 && prev_ram_reset !== 1'b1) reset_pulses++;
            prev_ack_next  = ram_ack_next;
            prev_ram_reset = ram_reset;
            prev_rq_ack    = rq_ack;
        end
    end

    // One complete transaction from a single requester, checked against the model.
    task automatic do_txn(input int who, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int            wr_hi_cycles;
        int            req_cycles;
        int            pulses0;
        bit            got;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
        exp_err      = ram_hang && !wr;
        exp_rd       = exp_err ? '0 : exp_mem[addr];
        pulses0      = reset_pulses;
        wr_hi_cycles = 0;
        req_cycles   = 0;
        got          = 1'b0;
        @(negedge clk);
        applyStimulus(who, wr, addr, data);
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (who == 0) begin
                    rq_addr0  = AW'($urandom);
                    rq_wdata0 = DW'($urandom);
                end else begin
                    rq_addr1  = AW'($urandom);
                    rq_wdata1 = DW'($urandom);
                end
                rq_write[who] = ~wr;
            end
            checkOutput("ram_addr_hold", 32'(ram_addr), 32'(addr));
            if (wr) checkOutput("ram_wdata_hold", 32'(ram_wdata), 32'(data));
            if (ram_write === 1'b1) wr_hi_cycles++;
            if (ram_req === 1'b1) req_cycles++;
            if (rq_ack[who] === 1'b1) got = 1'b1;
        end
        checkOutput("ack_seen", 32'(got), 32'd1);
        checkOutput("other_ack_low", 32'(rq_ack[1-who]), 32'd0);
        checkOutput("rq_err", 32'(rq_err[who]), 32'(exp_err));
        if (!wr) checkOutput("rq_rdata", 32'(rq_rdata), 32'(exp_rd));
        if (wr) checkOutput("write_pulse_cycles", 32'(wr_hi_cycles), 32'(WRC));
        if (exp_err) checkOutput("timeout_req_cycles", 32'(req_cycles), 32'(TOC));
        checkOutput("ram_reset_pulses", 32'(reset_pulses - pulses0), exp_err ? 32'd1 : 32'd0);
        rq_req[who] = 1'b0;
        @(negedge clk);
        checkOutput("ack_release", 32'(rq_ack[who]), 32'd0);
        if (wr) begin
            exp_mem[addr]   = data;
            exp_valid[addr] = 1'b1;
        end
        exp_ptr = 1 - who;
    endtask

    // Directed and randomized sequence.
    initial begin
        logic [DW-1:0] d0, d1, dat;
        logic [AW-1:0] a;
        logic [1:0]    onehot;
        bit            got;
        bit            wr;
        int            who;
        int            nxt;

        d0        = DW'($urandom);
        d1        = DW'($urandom);
        reset     = 1'b0;
        rq_req    = 2'b11;
        rq_write  = 2'b11;
        rq_addr0  = 8'h10;
        rq_addr1  = 8'h11;
        rq_wdata0 = d0;
        rq_wdata1 = d1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rq_ack", 32'(rq_ack), 32'd0);
        checkOutput("reset_rq_err", 32'(rq_err), 32'd0);
        checkOutput("reset_ram_req", 32'(ram_req), 32'd0);
        checkOutput("reset_ram_write", 32'(ram_write), 32'd0);
        checkOutput("reset_ram_ack_next", 32'(ram_ack_next), 32'd0);
        checkOutput("reset_ram_reset", 32'(ram_reset), 32'd1);
        checkOutput("reset_rq_rdata", 32'(rq_rdata), 32'd0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
        reset = 1'b1;

        // Both requesting out of reset: requester 0 first, then 1.
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (rq_ack !== 2'b00) got = 1'b1;
        end
        checkOutput("first_grant", 32'(rq_ack), 32'd1);
        rq_req[0] = 1'b0;
        @(negedge clk);
        checkOutput("first_release", 32'(rq_ack), 32'd0);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (rq_ack !== 2'b00) got = 1'b1;
        end
        checkOutput("second_grant", 32'(rq_ack), 32'd2);
        rq_req[1] = 1'b0;
        @(negedge clk);
        exp_mem[8'h10] = d0; exp_valid[8'h10] = 1'b1;
        exp_mem[8'h11] = d1; exp_valid[8'h11] = 1'b1;
        exp_ptr = 0;
        do_txn(0, 1'b0, 8'h10, 8'h00);
        do_txn(1, 1'b0, 8'h11, 8'h00);

        // Write then read back at 3C.
        do_txn(0, 1'b1, 8'h3C, 8'hA5);
        do_txn(0, 1'b0, 8'h3C, 8'h00);

        // Randomized single-requester traffic over a small address window.
        for (int n = 0; n < 14; n++) begin
            who = int'($urandom_range(0, 1));
            a   = 8'h40 + AW'($urandom_range(0, 15));
            wr  = !exp_valid[a] || ($urandom_range(0, 1) == 1);
            dat = DW'($urandom);
            do_txn(who, wr, a, dat);
        end

        // Requester drops its request before the ack: one-cycle ack pulse.
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h3C, 8'h00);
        repeat (2) @(negedge clk);
        rq_req[0] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (rq_ack[0] === 1'b1) got = 1'b1;
        end
        checkOutput("early_drop_ack", 32'(got), 32'd1);
        checkOutput("early_drop_rdata", 32'(rq_rdata), 32'(exp_mem[8'h3C]));
        @(negedge clk);
        checkOutput("early_drop_pulse", 32'(rq_ack), 32'd0);
        exp_ptr = 1;

        // Contention: both hold reads, grants must alternate.
        do_txn(0, 1'b1, 8'h01, DW'($urandom));
        do_txn(1, 1'b1, 8'h02, DW'($urandom));
        @(negedge clk);
        rq_write  = 2'b00;
        rq_addr0  = 8'h01;
        rq_addr1  = 8'h02;
        rq_req    = 2'b11;
        nxt       = exp_ptr;
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (rq_ack !== 2'b00) got = 1'b1;
            end
            onehot = (nxt == 0) ? 2'b01 : 2'b10;
            checkOutput("rr_grant", 32'(rq_ack), 32'(onehot));
            checkOutput("rr_rdata", 32'(rq_rdata), 32'(exp_mem[(nxt == 0) ? 8'h01 : 8'h02]));
            checkOutput("rr_err", 32'(rq_err), 32'd0);
            rq_req[nxt] = 1'b0;
            @(negedge clk);
            checkOutput("rr_release", 32'(rq_ack[nxt]), 32'd0);
            if (k < 6) rq_req[nxt] = 1'b1;
            nxt = 1 - nxt;
        end
        exp_ptr = nxt;

        // Timeout: RAM never answers, then normal service resumes.
        ram_hang = 1'b1;
        do_txn(1, 1'b0, 8'h3C, 8'h00);
        ram_hang = 1'b0;
        do_txn(0, 1'b0, 8'h02, 8'h00);

        // Reset in the middle of a read; the held request is served again.
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h3C, 8'h00);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ram_req === 1'b1) got = 1'b1;
        end
        checkOutput("midreset_in_read", 32'(got), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_ram_req", 32'(ram_req), 32'd0);
        checkOutput("midreset_rq_ack", 32'(rq_ack), 32'd0);
        checkOutput("midreset_ram_reset", 32'(ram_reset), 32'd1);
        checkOutput("midreset_ack_next", 32'(ram_ack_next), 32'd0);
        reset = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (rq_ack[0] === 1'b1) got = 1'b1;
        end
        checkOutput("midreset_reserved", 32'(got), 32'd1);
        checkOutput("midreset_rdata", 32'(rq_rdata), 32'(exp_mem[8'h3C]));
        checkOutput("midreset_err", 32'(rq_err), 32'd0);
        rq_req[0] = 1'b0;
        @(negedge clk);
        checkOutput("midreset_release", 32'(rq_ack), 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
